// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, burst-holding arbiter that shares the push
// port of one width-converting FIFO among N_REQ valid/ready producers.
// One grant is held for up to MAX_BURST transfers. A released grant always
// spends one IDLE cycle before the next grant is issued.
// Optional build macro FIFO_PUSH_ARB_STATS_EN adds one saturating 16-bit
// transfer counter per requester on output push_count.

// Per-requester slice: decodes its own select from the shared grant and
// owns that requester's transfer counter when stats are built in.
module fifo_push_arb_lane #(
  parameter int ID_W = 2,
  parameter int LANE = 0
) (
`ifdef FIFO_PUSH_ARB_STATS_EN
  input  logic            clk,
  input  logic            rst_n,
`endif
  input  logic            busy,
  input  logic [ID_W-1:0] grant_id,
  input  logic            valid,
  input  logic            full,
  output logic            ready,
  output logic            xfer
`ifdef FIFO_PUSH_ARB_STATS_EN
  ,
  output logic [15:0]     count
`endif
);
  logic sel;

  // Only the granted lane may accept. Full gates ready in the same cycle,
  // so there is no slack for an overflow.
  assign sel   = busy && (grant_id == ID_W'(LANE));
  assign ready = sel && !full;
  assign xfer  = ready && valid;

`ifdef FIFO_PUSH_ARB_STATS_EN
  // Saturating count of words accepted from this requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (xfer && (count != 16'hFFFF))
      count <= count + 16'd1;
  end
`endif
endmodule

module fifo_push_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   fifo_push,
  output logic [WIDTH-1:0]       fifo_d,
  input  logic                   fifo_full,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
`ifdef FIFO_PUSH_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]    push_count
`endif
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [7:0]       burst_cnt;

  logic [N_REQ-1:0] xfer_vec;
  logic             xfer;
  logic             valid_g;
  logic [WIDTH-1:0] d_sel;
  logic [ID_W-1:0]  pick;
  logic             found;
  int               idx;
  logic             any_req;
  logic             last_beat;
  logic             release_g;
  logic [ID_W-1:0]  rr_next;

  assign busy = (state == S_GRANT);

  // One lane slice per requester, producing its ready and transfer strobe.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    fifo_push_arb_lane #(.ID_W(ID_W), .LANE(i)) u_lane (
`ifdef FIFO_PUSH_ARB_STATS_EN
      .clk      (clk),
      .rst_n    (rst_n),
`endif
      .busy     (busy),
      .grant_id (grant_id),
      .valid    (req_valid[i]),
      .full     (fifo_full),
      .ready    (req_ready[i]),
      .xfer     (xfer_vec[i])
`ifdef FIFO_PUSH_ARB_STATS_EN
      ,
      .count    (push_count[i*16 +: 16])
`endif
    );
  end

  // At most one lane is selected, so OR-ing the strobes gives the push.
  assign xfer      = |xfer_vec;
  assign fifo_push = xfer;

  // Select the granted requester's valid and data.
  always_comb begin
    valid_g = 1'b0;
    d_sel   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        valid_g = req_valid[i];
        d_sel   = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Data is forced to zero while idle, so reset drops it asynchronously.
  assign fifo_d = busy ? d_sel : '0;

  // Round-robin pick: the first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign any_req   = |req_valid;
  assign last_beat = xfer && (burst_cnt == 8'(MAX_BURST - 1));
  // Release happens on the last permitted beat, or when the owner goes quiet.
  // A stalled owner (valid while full) keeps the grant.
  assign release_g = busy && (last_beat || (!valid_g && !xfer));
  assign rr_next   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  // Grant FSM: IDLE picks an owner, GRANT counts beats until release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant_id  <= pick;
            burst_cnt <= '0;
            state     <= S_GRANT;
          end
        end
        default: begin
          if (xfer)
            burst_cnt <= burst_cnt + 8'd1;
          if (release_g) begin
            rr_ptr <= rr_next;
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter. The stimulus process drives each
// cycle and queues the reference model's expected outputs. The monitor pops
// one entry on every falling edge and compares it with the DUT.
module tb_fifo_push_arbiter;
  localparam int N_REQ = 4, WIDTH = 8, MAX_BURST = 4, ID_W = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid, req_ready;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic                   fifo_push, fifo_full, busy;
  logic [WIDTH-1:0]       fifo_d;
  logic [ID_W-1:0]        grant_id;
`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [N_REQ*16-1:0]    push_count;
`endif

  fifo_push_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_push(fifo_push), .fifo_d(fifo_d),
    .fifo_full(fifo_full), .busy(busy), .grant_id(grant_id)
`ifdef FIFO_PUSH_ARB_STATS_EN
    , .push_count(push_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             busy;
    int               gid;
    logic [N_REQ-1:0] ready;
    logic             push;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t             expq[$];
  logic [WIDTH-1:0] pend[N_REQ][$];   // words each producer still has to send
  int               owner, taken, nextp;
  int               pcnt[N_REQ];
  int               vectors = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; taken = 0; nextp = 0;
    for (int i = 0; i < N_REQ; i++) pcnt[i] = 0;
  endtask

  // Apply one cycle of stimulus, queue the expected outputs, and advance the model.
  task automatic step(input logic [N_REQ-1:0] want, input logic full);
    logic [N_REQ-1:0] v;
    logic [WIDTH-1:0] dd[N_REQ];
    exp_t e;
    logic found;
    for (int i = 0; i < N_REQ; i++) begin
      v[i]  = want[i] && (pend[i].size() > 0);
      dd[i] = (pend[i].size() > 0) ? pend[i][0] : '0;
      req_data[i*WIDTH +: WIDTH] = dd[i];
    end
    req_valid = v;
    fifo_full = full;
    e.busy  = (owner >= 0);
    e.gid   = owner;
    e.ready = '0;
    e.push  = 1'b0;
    e.d     = '0;
    if (owner >= 0) begin
      e.d = dd[owner];
      if (!full) e.ready[owner] = 1'b1;
      e.push = v[owner] && !full;
    end
    expq.push_back(e);
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && v[(nextp + k) % N_REQ]) begin
          found = 1'b1;
          owner = (nextp + k) % N_REQ;
        end
      end
      taken = 0;
    end else if (e.push) begin
      void'(pend[owner].pop_front());
      pcnt[owner]++;
      taken++;
      if (taken == MAX_BURST) begin nextp = (owner + 1) % N_REQ; owner = -1; end
    end else if (!v[owner]) begin
      nextp = (owner + 1) % N_REQ;
      owner = -1;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_stats();
`ifdef FIFO_PUSH_ARB_STATS_EN
    for (int i = 0; i < N_REQ; i++) chk("push_count", 64'(push_count[i*16 +: 16]), 64'(pcnt[i]));
`endif
  endtask

  // Monitor: compare each queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("busy", 64'(busy), 64'(e.busy));
        chk("req_ready", 64'(req_ready), 64'(e.ready));
        chk("fifo_push", 64'(fifo_push), 64'(e.push));
        chk("fifo_d", 64'(fifo_d), 64'(e.d));
        if (e.busy) chk("grant_id", 64'(grant_id), 64'(e.gid));
        chk("push_while_full", 64'(fifo_push & fifo_full), 64'(0));
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_push", 64'(fifo_push), 64'(0));
    chk("rst_d", 64'(fifo_d), 64'(0));
    chk("rst_gid", 64'(grant_id), 64'(0));
    rst_n = 1'b1;

    // Single requester, three words, then valid drops.
    pend[0].push_back(8'h11); pend[0].push_back(8'h22); pend[0].push_back(8'h33);
    repeat (7) step(4'b0001, 1'b0);

    // Fairness between two continuously valid requesters.
    for (int i = 0; i < 12; i++) begin
      pend[0].push_back(8'(8'h40 + i));
      pend[1].push_back(8'(8'h80 + i));
    end
    repeat (16) step(4'b0011, 1'b0);
    check_stats();
    repeat (10) step(4'b0011, 1'b0);
    repeat (2) step(4'b0000, 1'b0);

    // Wrap: grant req2 to move the pointer to 3, then present req1 and req3.
    pend[2].push_back(8'hA0);
    repeat (3) step(4'b0100, 1'b0);
    for (int i = 0; i < 2; i++) begin
      pend[1].push_back(8'(8'hB0 + i));
      pend[3].push_back(8'(8'hC0 + i));
    end
    repeat (9) step(4'b1010, 1'b0);

    // Full stall on req2: hold while full, then exactly one push per free slot.
    for (int i = 0; i < 4; i++) pend[2].push_back(8'(8'hD0 + i));
    step(4'b0100, 1'b1);
    repeat (4) step(4'b0100, 1'b1);
    step(4'b0100, 1'b0);
    repeat (3) step(4'b0100, 1'b1);
    repeat (5) step(4'b0100, 1'b0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_REQ; i++)
        if (pend[i].size() < 3) pend[i].push_back(8'($urandom));
      step(4'($urandom), ($urandom_range(0, 3) == 0));
    end
    check_stats();

    // Reset mid-burst: drain everything, then reset after two of four words.
    for (int i = 0; i < N_REQ; i++) pend[i].delete();
    repeat (2) step(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) pend[0].push_back(8'(8'hE0 + i));
    repeat (3) step(4'b0001, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(0));
    chk("midrst_push", 64'(fifo_push), 64'(0));
    chk("midrst_d", 64'(fifo_d), 64'(0));
    model_reset();
    check_stats();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) step(4'b0001, 1'b0);
    check_stats();

    @(negedge clk);
    chk("queue_drained", 64'(expq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
